// File: rtl/shared_bus_receiver.sv
// Receives words from the shared bus over a four-phase req/ack handshake and buffers them in a FIFO.
// The output is a first-word fall-through valid/ready stream in the clkC domain.
module shared_bus_receiver #(
   parameter int DATA_W      = 64,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic                     clkC_i,
   input  logic                     rst_i,
   input  logic [DATA_W-1:0]        busData_i,
   input  logic                     busReq_i,
   output logic                     busAck_o,
   output logic [DATA_W-1:0]        outData_o,
   output logic                     outValid_o,
   input  logic                     outReady_i,
   output logic [$clog2(DEPTH):0]   fifoLevel_o,
   output logic [CNT_W-1:0]         wordCount_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {S_IDLE, S_ACK} state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_s;
   state_t                 state_q;
   logic                   ack_q;
   logic [DATA_W-1:0]      mem_q [DEPTH];
   logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]          level_q, level_d;
   logic                   valid_q;
   logic [CNT_W-1:0]       count_q;
   logic                   push, pop;

   assign req_s = sync_q[SYNC_STAGES-1];

   // Full is judged on the level before this edge, so a same-cycle pop never frees a slot for a push.
   assign push = (state_q == S_IDLE) && req_s && (level_q != LW'(DEPTH));
   assign pop  = valid_q && outReady_i;

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clkC_i or negedge rst_i) begin
      if (!rst_i) begin
         sync_q   <= '0;
         state_q  <= S_IDLE;
         ack_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         valid_q  <= 1'b0;
         count_q  <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], busReq_i};
         level_q <= level_d;
         valid_q <= (level_d != '0);
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            count_q  <= count_q + CNT_W'(1);
         end
         if (pop)
            rd_ptr_q <= rd_ptr_q + AW'(1);
         case (state_q)
            S_IDLE: if (push) begin
               state_q <= S_ACK;
               ack_q   <= 1'b1;
            end
            S_ACK: if (!req_s) begin
               state_q <= S_IDLE;
               ack_q   <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               ack_q   <= 1'b0;
            end
         endcase
      end
   end

   // Storage needs no reset: outData is masked until the level says a slot is live.
   always_ff @(posedge clkC_i) begin
      if (push)
         mem_q[wr_ptr_q] <= busData_i;
   end

   assign busAck_o    = ack_q;
   assign outValid_o  = valid_q;
   assign outData_o   = valid_q ? mem_q[rd_ptr_q] : '0;
   assign fifoLevel_o = level_q;
   assign wordCount_o = count_q;

endmodule
